// File: rtl/regfile_pkg.sv
// Shared constants and the entry-masking helper used by the write path and both read ports.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 3;
  localparam int DEPTH_DEF = 8;

  // An entry is live when it is inside the array and is not the hard-wired zero register.
  // Dead entries read as 0 and ignore writes.
  function automatic logic entry_live(input int unsigned addr, input int unsigned depth,
                                      input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port. With REGFILE_BYPASS_EN defined, a same-cycle write to the
// addressed live entry is forwarded (write-through); otherwise the old contents are returned.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      rd_en,
  input  logic [AW-1:0]             ra,
  input  logic [DEPTH-1:0][DW-1:0]  mem,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wa,
  input  logic [DW-1:0]             wd,
  output logic [DW-1:0]             rd
);

  logic [DW-1:0] ent;
  logic [DW-1:0] rd_d, rd_q;

  always_comb begin
    ent = '0;
    for (int i = 0; i < DEPTH; i++)
      if (AW'(i) == ra) ent = mem[i];
    if (!entry_live(32'(ra), DEPTH, ZERO_REG != 0)) ent = '0;
`ifdef REGFILE_BYPASS_EN
    // wr_en is only high for live entries, so the zero register never forwards.
    if (wr_en && (wa == ra)) ent = wd;
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_en, wa, wd};
`endif

  always_comb begin
    rd_d = rd_q;
    if (rd_en) rd_d = ent;
  end

  always_ff @(posedge clk) begin
    if (!clr) rd_q <= '0;
    else      rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/register_file_param.sv
// Parameterised 1W/2R register file with registered reads, chip enable and optional zero register.
// Optional write-through on same-address read/write: define REGFILE_BYPASS_EN.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          rvalid
);

  logic [DEPTH-1:0][DW-1:0] mem_d, mem_q;
  logic                     rvalid_d, rvalid_q;
  logic                     wr_en, rd_en;

  assign wr_en = ce && we && entry_live(32'(wa), DEPTH, ZERO_REG != 0);
  assign rd_en = ce && re;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (wr_en && (AW'(i) == wa)) mem_d[i] = wd;
    rvalid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      mem_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Both ports see pre-write memory; any forwarding happens inside the port.
  regfile_rd_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd0 (
    .clk(clk), .clr(clr), .rd_en(rd_en), .ra(ra0), .mem(mem_q),
    .wr_en(wr_en), .wa(wa), .wd(wd), .rd(rd0)
  );

  regfile_rd_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd1 (
    .clk(clk), .clr(clr), .rd_en(rd_en), .ra(ra1), .mem(mem_q),
    .wr_en(wr_en), .wa(wa), .wd(wd), .rd(rd1)
  );

  assign rvalid = rvalid_q;

endmodule
